// File: rtl/silife_host_pkg.sv
// rtl/silife_host_pkg.sv - shared opcodes, state encoding and grid geometry for the SiLife host initiator
package silife_host_pkg;

  localparam int ROWS = 8;
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP_CNT,
    ST_STEP_RUN,
    ST_DUMP_SEL,
    ST_DUMP_WAIT,
    ST_DUMP_SEND
  } state_t;

endpackage

// File: rtl/silife_host_ctrl.sv
// rtl/silife_host_ctrl.sv - byte-command initiator driving the 8x8 SiLife grid pins
module silife_host_ctrl
  import silife_host_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic [2:0] row_select,
  output logic       grid_en,
  output logic       grid_wr_en,
  output logic [7:0] grid_wdata,
  input  logic [7:0] grid_rdata
);

  localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

  state_t     state;
  logic [2:0] row;
  logic [7:0] cnt;
  logic [1:0] wait_cnt;
  logic       cmd_fire;

  assign cmd_fire = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row        <= '0;
      cnt        <= '0;
      wait_cnt   <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      row_select <= '0;
      grid_en    <= 1'b0;
      grid_wr_en <= 1'b0;
      grid_wdata <= '0;
    end else begin
      // write strobe and its data are single-cycle pulses; the grid must see zero otherwise
      grid_wr_en <= 1'b0;
      grid_wdata <= '0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            case (cmd_data[7:6])
              OP_NOP: ;
              OP_LOAD: begin
                state <= ST_LOAD;
                row   <= '0;
                busy  <= 1'b1;
              end
              OP_STEP: begin
                state <= ST_STEP_CNT;
                busy  <= 1'b1;
              end
              OP_DUMP: begin
                state      <= ST_DUMP_SEL;
                row        <= '0;
                row_select <= '0;
                busy       <= 1'b1;
                cmd_ready  <= 1'b0;
              end
            endcase
          end
        end
        ST_LOAD: begin
          if (cmd_fire) begin
            grid_wr_en <= 1'b1;
            grid_wdata <= cmd_data;
            row_select <= row;
            row        <= row + 3'd1;
            if (row == LAST_ROW) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_STEP_CNT: begin
          if (cmd_fire) begin
            if (cmd_data == 8'd0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt       <= cmd_data;
              grid_en   <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= ST_STEP_RUN;
            end
          end
        end
        ST_STEP_RUN: begin
          if (cnt == 8'd1) begin
            grid_en   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DUMP_SEL: begin
          // row_select is already on the pins this cycle; count the grid's read latency from here
          wait_cnt <= WAIT_INIT;
          state    <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_data  <= grid_rdata;
            rsp_valid <= 1'b1;
            state     <= ST_DUMP_SEND;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_DUMP_SEND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            row       <= row + 3'd1;
            if (row == LAST_ROW) begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              row_select <= row + 3'd1;
              state      <= ST_DUMP_SEL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_silife_host_ctrl.sv
// tb/tb_silife_host_ctrl.sv - scoreboard bench for silife_host_ctrl with READ_LAT 1 and 3 instances
module tb_silife_host_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, grid_en, grid_wr_en;
  logic [1:0][7:0] cmd_data, rsp_data, grid_wdata, grid_rdata;
  logic [1:0][2:0] row_select;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit rnd_ready = 1'b0;

  typedef struct { int cyc; logic [2:0] row; logic [7:0] data; } wr_t;
  typedef struct { int cyc; int n; } step_t;
  wr_t        wr_q[$];
  step_t      step_q[$];
  logic [7:0] rsp_q[$];

  logic [63:0] ref_g [2];
  int          run_len [2], run_start [2], dump_ref [2], rsp_cnt [2];
  logic        pv [2], phs [2];
  logic [7:0]  pd [2];

  // Conway's rule on an 8x8 field with dead cells beyond the edges
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int k;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              k += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = (k == 3) || (g[r * 8 + c] && k == 2);
      end
    return n;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [63:0] cells = '0;
    logic [2:0]  rs_pipe [3] = '{default: 3'd0};

    silife_host_ctrl #(.READ_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_data   (cmd_data[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .busy       (busy[g]),
      .row_select (row_select[g]),
      .grid_en    (grid_en[g]),
      .grid_wr_en (grid_wr_en[g]),
      .grid_wdata (grid_wdata[g]),
      .grid_rdata (grid_rdata[g])
    );

    always @(posedge clk) begin
      if (grid_wr_en[g]) cells[{row_select[g], 3'b000} +: 8] <= grid_wdata[g];
      else if (grid_en[g]) cells <= life(cells);
      rs_pipe[0] <= row_select[g];
      rs_pipe[1] <= rs_pipe[0];
      rs_pipe[2] <= rs_pipe[1];
    end
    assign grid_rdata[g] = cells[{rs_pipe[LAT-1], 3'b000} +: 8];
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops scoreboard entries whenever the DUTs present writes, generation runs or dump bytes
  initial begin
    wr_t e;
    step_t s;
    for (int d = 0; d < 2; d++) begin
      run_len[d] = 0; run_start[d] = 0; dump_ref[d] = 0; rsp_cnt[d] = 0; pv[d] = 0; phs[d] = 0; pd[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          run_len[d] = 0;
          pv[d] = 0;
          phs[d] = 0;
        end else begin
          check_eq("en_wr_excl", int'(grid_en[d] & grid_wr_en[d]), 0);
          if (grid_wr_en[d]) begin
            if (wr_q.size() == 0) check_eq("wr_unexpected", int'(grid_wr_en[d]), 0);
            else begin
              e = wr_q.pop_front();
              check_eq("wr_cycle", cyc, e.cyc);
              check_eq("wr_row", int'(row_select[d]), int'(e.row));
              check_eq("wr_data", int'(grid_wdata[d]), int'(e.data));
            end
          end else begin
            check_eq("wdata_idle", int'(grid_wdata[d]), 0);
          end
          if (grid_en[d]) begin
            if (run_len[d] == 0) run_start[d] = cyc;
            run_len[d]++;
            check_eq("ready_in_run", int'(cmd_ready[d]), 0);
          end else if (run_len[d] > 0) begin
            if (step_q.size() == 0) check_eq("run_unexpected", run_len[d], 0);
            else begin
              s = step_q.pop_front();
              check_eq("run_start", run_start[d], s.cyc);
              check_eq("run_len", run_len[d], s.n);
            end
            check_eq("run_end_busy", int'(busy[d]), 0);
            check_eq("run_end_ready", int'(cmd_ready[d]), 1);
            run_len[d] = 0;
          end
          if (pv[d] && !phs[d]) begin
            check_eq("rsp_hold", int'(rsp_valid[d]), 1);
            check_eq("rsp_stable", int'(rsp_data[d]), int'(pd[d]));
          end
          if (rsp_valid[d] && !pv[d]) check_eq("rsp_latency", cyc, dump_ref[d] + ((d == 0) ? 1 : 3) + 2);
          if (rsp_valid[d]) check_eq("ready_in_dump", int'(cmd_ready[d]), 0);
          phs[d] = rsp_valid[d] && rsp_ready[d];
          if (phs[d]) begin
            if (rsp_q.size() == 0) check_eq("rsp_unexpected", int'(rsp_valid[d]), 0);
            else check_eq("rsp_data", int'(rsp_data[d]), int'(rsp_q.pop_front()));
            dump_ref[d] = cyc;
            rsp_cnt[d]++;
          end
          pv[d] = rsp_valid[d];
          pd[d] = rsp_data[d];
        end
      end
    end
  end

  initial begin
    rsp_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) rsp_ready[d] = rnd_ready ? 1'($urandom) : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, output int t);
    bit done;
    done = 0;
    t = -1;
    cmd_valid[d] = 1'b1;
    cmd_data[d] = b;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready[d]) begin t = cyc; done = 1; end
    end
    check_eq("cmd_accept", int'(done), 1);
    if (done) begin @(posedge clk); #1; end
    cmd_valid[d] = 1'b0;
    cmd_data[d] = 8'($urandom);
  endtask

  task automatic do_load(input int d, input logic [63:0] pat, input int gap);
    int t, tp;
    send_byte(d, {2'b01, 6'($urandom)}, tp);
    for (int r = 0; r < 8; r++) begin
      send_byte(d, pat[r*8 +: 8], t);
      if (t >= 0) wr_q.push_back('{t + 1, 3'(r), pat[r*8 +: 8]});
      if (gap == 0) check_eq("load_b2b", t, tp + 1);
      tp = t;
      idle(gap);
    end
    ref_g[d] = pat;
  endtask

  task automatic do_step(input int d, input int n);
    int t;
    send_byte(d, {2'b10, 6'($urandom)}, t);
    send_byte(d, 8'(n), t);
    if (n != 0) step_q.push_back('{t + 1, n});
    else begin
      @(negedge clk);
      check_eq("step0_busy", int'(busy[d]), 0);
      check_eq("step0_ready", int'(cmd_ready[d]), 1);
      @(posedge clk); #1;
    end
    repeat (n) ref_g[d] = life(ref_g[d]);
  endtask

  task automatic wait_rsp(input int d, input int target);
    for (int i = 0; i < 3000 && rsp_cnt[d] < target; i++) @(negedge clk);
    check_eq("dump_done", int'(rsp_cnt[d] >= target), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_dump(input int d, input bit wait_all);
    int t, base;
    base = rsp_cnt[d];
    send_byte(d, {2'b11, 6'($urandom)}, t);
    dump_ref[d] = t;
    for (int r = 0; r < 8; r++) rsp_q.push_back(ref_g[d][r*8 +: 8]);
    if (wait_all) wait_rsp(d, base + 8);
  endtask

  task automatic check_rst(input int d);
    check_eq("rst_cmd_ready", int'(cmd_ready[d]), 0);
    check_eq("rst_rsp_valid", int'(rsp_valid[d]), 0);
    check_eq("rst_rsp_data", int'(rsp_data[d]), 0);
    check_eq("rst_busy", int'(busy[d]), 0);
    check_eq("rst_row_select", int'(row_select[d]), 0);
    check_eq("rst_grid_en", int'(grid_en[d]), 0);
    check_eq("rst_grid_wr_en", int'(grid_wr_en[d]), 0);
    check_eq("rst_grid_wdata", int'(grid_wdata[d]), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_rst(0);
    check_rst(1);
    rst_n = 1'b1;
    wr_q.delete();
    step_q.delete();
    rsp_q.delete();
    @(posedge clk); #1;
    check_eq("ready_after_rst", int'(cmd_ready[0]), 1);
  endtask

  localparam logic [63:0] BLINKER = 64'h0000_0404_0400_0000;

  initial begin
    int t;
    rst_n = 1'b0;
    cmd_valid = '0;
    cmd_data = '0;
    ref_g[0] = '0;
    ref_g[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_rst(0);
    check_rst(1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", int'(cmd_ready[0]), 1);
    check_eq("ready_after_rst1", int'(cmd_ready[1]), 1);

    do_load(0, 64'h8040_2010_0804_0201, 0);
    do_dump(0, 1);
    do_load(0, BLINKER, 2);
    do_dump(0, 1);
    do_step(0, 5);
    do_dump(0, 1);
    do_step(0, 0);
    send_byte(0, {2'b00, 6'($urandom)}, t);
    @(negedge clk);
    check_eq("nop_busy", int'(busy[0]), 0);
    @(posedge clk); #1;

    for (int it = 0; it < 4; it++) begin
      do_load(0, {$urandom, $urandom}, $urandom_range(0, 2));
      do_step(0, $urandom_range(1, 20));
      rnd_ready = (it % 2) == 1;
      do_dump(0, 1);
    end
    rnd_ready = 1'b0;

    send_byte(0, 8'h80, t);
    send_byte(0, 8'd10, t);
    for (int i = 0; i < 100 && run_len[0] < 7; i++) @(negedge clk);
    check_eq("run_reached", run_len[0], 7);
    pulse_reset();
    do_load(0, {$urandom, $urandom}, 1);
    do_dump(0, 1);

    do_dump(0, 0);
    wait_rsp(0, rsp_cnt[0] + 0);
    for (int i = 0; i < 200 && rsp_q.size() > 4; i++) @(negedge clk);
    check_eq("dump_partial", rsp_q.size(), 4);
    pulse_reset();
    send_byte(0, 8'h00, t);
    @(negedge clk);
    check_eq("nop_after_rst", int'(busy[0]), 0);
    @(posedge clk); #1;
    do_load(0, BLINKER, 0);
    do_dump(0, 1);

    do_load(1, BLINKER, 1);
    do_dump(1, 1);
    do_step(1, 1);
    rnd_ready = 1'b1;
    do_dump(1, 1);
    do_step(1, 3);
    do_dump(1, 1);
    rnd_ready = 1'b0;

    idle(5);
    check_eq("wr_q_empty", wr_q.size(), 0);
    check_eq("step_q_empty", step_q.size(), 0);
    check_eq("rsp_q_empty", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
